// File: rtl/rr_pkt_arb.sv
// rtl/rr_pkt_arb.sv - round-robin packet arbiter for one NoC router output port
// Holds a grant for a whole packet; re-arbitrates on the release edge so packets run back to back.
module rr_pkt_arb #(
   parameter int N_PORTS   = 5,
   parameter int IDX_W     = 3,
   parameter int PKT_FLITS = 5,
   parameter bit TAIL_MODE = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_PORTS-1:0] req_i,
   input  logic [N_PORTS-1:0] mask_i,
   input  logic               flit_valid_i,
   input  logic               tail_i,
   output logic               grant_vld_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic [N_PORTS-1:0] grant_oh_o
);

   localparam int               CNT_W    = $clog2(PKT_FLITS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_FLITS - 1);
   localparam logic [IDX_W-1:0] IDX_NONE = '1;
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_PORTS - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N_PORTS-1:0] oh_q, oh_d;
   logic               vld_q, vld_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [N_PORTS-1:0] elig;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic               release_pkt;
   logic               arb;

   assign elig = req_i & ~mask_i;

   // Ports above the last winner take precedence over the wrapped ones; lowest index wins within each group.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int j = N_PORTS - 1; j >= 0; j--) begin
         if (elig[j] && (IDX_W'(j) <= last_q)) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(j);
         end
      end
      for (int j = N_PORTS - 1; j >= 0; j--) begin
         if (elig[j] && (IDX_W'(j) > last_q)) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(j);
         end
      end
   end

   always_comb begin
      if (TAIL_MODE)
         release_pkt = flit_valid_i && tail_i;
      else
         release_pkt = flit_valid_i && (cnt_q == CNT_LAST);
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      arb     = 1'b0;
      case (state_q)
         IDLE: arb = 1'b1;
         HOLD: begin
            if (release_pkt)
               arb = 1'b1;
            else if (flit_valid_i && (cnt_q != CNT_LAST))
               cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (arb) begin
         cnt_d = '0;
         if (pick_vld) begin
            state_d = HOLD;
            last_d  = pick_idx;
            idx_d   = pick_idx;
            oh_d    = N_PORTS'(1) << pick_idx;
            vld_d   = 1'b1;
         end else begin
            state_d = IDLE;
            idx_d   = IDX_NONE;
            oh_d    = '0;
            vld_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= IDX_TOP;
         idx_q   <= IDX_NONE;
         oh_q    <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_vld_o = vld_q;
   assign grant_idx_o = idx_q;
   assign grant_oh_o  = oh_q;

endmodule
